vsfx_pipe: RTL and testbench

- Parametrised, pipelined successor to the vector simple fixed-point unit.
- Executes element-wise integer add/sub (modulo or saturating), max/min, average and compare on byte, halfword or word lanes of a VW-bit vector.
- Latency is configurable. Every result carries a valid flag, per-op saturation, an optional CR6 update and a sticky VSCR[SAT] image.
- Instantiated by the vector issue stage in place of the single-cycle unit.

---
 rtl/vsfx_pipe.sv | 213 +++++++++++++++++++++
 tb/tb_vsfx_pipe.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vsfx_pipe.sv
// vsfx_pipe: pipelined vector fixed-point add/sub/max/min/avg/compare on byte, half or word lanes.
// Latency: LAT cycles from en to vrt_en. Lanes are computed in stage 1; stages 2..LAT only delay the result.
// Backpressure: none. One op is accepted per cycle. flush kills in-flight ops but keeps a same-cycle en.
// Ports: clk/rst (async, active-high); en, vra, vrb, op = issue; flush, sat_clr = control;
//        vrt_en, vrt, sat, cr6_en, cr6 = registered result (held while vrt_en=0); sat_sticky = VSCR[SAT].
module vsfx_pipe #(
  parameter int VW  = 128,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [VW-1:0] vra,
  input  logic [VW-1:0] vrb,
  input  logic [7:0]    op,
  input  logic          flush,
  input  logic          sat_clr,
  output logic          vrt_en,
  output logic [VW-1:0] vrt,
  output logic          sat,
  output logic          cr6_en,
  output logic [3:0]    cr6,
  output logic          sat_sticky
);

  localparam int NB = VW / 8;
  localparam int NH = VW / 16;
  localparam int NW = VW / 32;

  typedef struct packed {
    logic          vld;
    logic          rec;
    logic          sat;
    logic [3:0]    cr6;
    logic [VW-1:0] vrt;
  } stage_t;

  typedef struct packed {
    logic [31:0] r;
    logic        sat;
    logic        t;
  } lane_res_t;

  // One lane of any width up to 32 bits. msb is the lane's top bit index.
  // Operands arrive zero-extended. They are widened to 34 signed bits so that
  // a 32-bit unsigned sum or difference still compares correctly against the clamp limits.
  function automatic lane_res_t lane_op(input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] msb, input logic [2:0] fn,
                                        input logic sgn, input logic satm);
    lane_res_t res;
    logic [31:0] msk;
    logic signed [33:0] ax, bx, sum, dif, maxv, minv, s;
    logic gt;
    msk  = 32'hFFFF_FFFF >> (5'd31 - msb);
    ax   = (sgn && a[msb]) ? {2'b11, a | ~msk} : {2'b00, a};
    bx   = (sgn && b[msb]) ? {2'b11, b | ~msk} : {2'b00, b};
    sum  = ax + bx;
    dif  = ax - bx;
    maxv = sgn ? {3'b000, msk[31:1]} : {2'b00, msk};
    // The signed minimum is -max-1, which equals ~max.
    minv = sgn ? ~{3'b000, msk[31:1]} : '0;
    gt   = ax > bx;
    s    = fn[0] ? dif : sum;
    res  = '0;
    case (fn)
      3'b000, 3'b001: begin
        res.r = s[31:0] & msk;
        if (satm && (s > maxv)) begin
          res.r   = maxv[31:0];
          res.sat = 1'b1;
        end else if (satm && (s < minv)) begin
          res.r   = minv[31:0] & msk;
          res.sat = 1'b1;
        end
      end
      3'b010: res.r = gt ? a : b;
      3'b011: res.r = gt ? b : a;
      3'b100: res.r = 32'((sum + 34'sd1) >>> 1) & msk;
      3'b101: begin
        res.t = (a == b);
        res.r = res.t ? msk : 32'd0;
      end
      3'b110: begin
        res.t = gt;
        res.r = res.t ? msk : 32'd0;
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // A stage takes new data only from a valid, unkilled input. cr6 changes only on
  // record-compare ops, so the output stage holds it across every other op.
  function automatic stage_t merge(input stage_t hold, input stage_t in_s, input logic kill);
    stage_t o;
    o     = hold;
    o.vld = in_s.vld & ~kill;
    if (o.vld) begin
      o.vrt = in_s.vrt;
      o.sat = in_s.sat;
      o.rec = in_s.rec;
      if (in_s.rec) o.cr6 = in_s.cr6;
    end
    return o;
  endfunction

  logic [2:0]    fn;
  logic          sgn;
  logic          satm;
  lane_res_t     lr;
  logic [VW-1:0] res_b, res_h, res_w;
  logic          sat_b, sat_h, sat_w;
  logic          all_b, all_h, all_w;
  logic          any_b, any_h, any_w;
  stage_t        comp;

  assign fn   = op[7:5];
  assign sgn  = op[2];
  assign satm = op[1];

  // Stage-1 compute: all three lane sizes are evaluated, and the element size field selects one.
  always_comb begin
    lr    = '0;
    res_b = '0;
    res_h = '0;
    res_w = '0;
    sat_b = 1'b0;
    sat_h = 1'b0;
    sat_w = 1'b0;
    all_b = 1'b1;
    all_h = 1'b1;
    all_w = 1'b1;
    any_b = 1'b0;
    any_h = 1'b0;
    any_w = 1'b0;
    for (int i = 0; i < NB; i++) begin
      lr = lane_op({24'd0, vra[i*8 +: 8]}, {24'd0, vrb[i*8 +: 8]}, 5'd7, fn, sgn, satm);
      res_b[i*8 +: 8] = lr.r[7:0];
      sat_b = sat_b | lr.sat;
      all_b = all_b & lr.t;
      any_b = any_b | lr.t;
    end
    for (int i = 0; i < NH; i++) begin
      lr = lane_op({16'd0, vra[i*16 +: 16]}, {16'd0, vrb[i*16 +: 16]}, 5'd15, fn, sgn, satm);
      res_h[i*16 +: 16] = lr.r[15:0];
      sat_h = sat_h | lr.sat;
      all_h = all_h & lr.t;
      any_h = any_h | lr.t;
    end
    for (int i = 0; i < NW; i++) begin
      lr = lane_op(vra[i*32 +: 32], vrb[i*32 +: 32], 5'd31, fn, sgn, satm);
      res_w[i*32 +: 32] = lr.r;
      sat_w = sat_w | lr.sat;
      all_w = all_w & lr.t;
      any_w = any_w | lr.t;
    end

    comp     = '0;
    comp.vld = en;
    comp.rec = op[0] & ((fn == 3'b101) || (fn == 3'b110));
    case (op[4:3])
      2'b00: begin
        comp.vrt = res_b;
        comp.sat = sat_b;
        comp.cr6 = {all_b, 1'b0, ~any_b, 1'b0};
      end
      2'b01: begin
        comp.vrt = res_h;
        comp.sat = sat_h;
        comp.cr6 = {all_h, 1'b0, ~any_h, 1'b0};
      end
      default: begin
        comp.vrt = res_w;
        comp.sat = sat_w;
        comp.cr6 = {all_w, 1'b0, ~any_w, 1'b0};
      end
    endcase
  end

  stage_t pipe_q [LAT];
  stage_t pipe_d [LAT];
  logic   sat_sticky_q;
  logic   sat_sticky_d;

  // Stage 0 always accepts en, even when flush is high. flush only clears the valid
  // bits moving into the later stages.
  always_comb begin
    pipe_d[0] = merge(pipe_q[0], comp, 1'b0);
    for (int k = 1; k < LAT; k++) begin
      pipe_d[k] = merge(pipe_q[k], pipe_q[k-1], flush);
    end
    // A coincident set beats sat_clr.
    sat_sticky_d = (sat_sticky_q & ~sat_clr) | (vrt_en & sat);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) pipe_q[k] <= '0;
      sat_sticky_q <= 1'b0;
    end else begin
      for (int k = 0; k < LAT; k++) pipe_q[k] <= pipe_d[k];
      sat_sticky_q <= sat_sticky_d;
    end
  end

  assign vrt_en     = pipe_q[LAT-1].vld;
  assign vrt        = pipe_q[LAT-1].vrt;
  assign sat        = pipe_q[LAT-1].sat;
  assign cr6_en     = pipe_q[LAT-1].vld & pipe_q[LAT-1].rec;
  assign cr6        = pipe_q[LAT-1].cr6;
  assign sat_sticky = sat_sticky_q;

endmodule

// File: tb/tb_vsfx_pipe.sv
module tb_vsfx_pipe;
  localparam int VW    = 128;
  localparam int LAT_M = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [VW-1:0] vra, vrb;
  logic [7:0]    op;
  logic          flush, sat_clr;

  logic          o_en, o_sat, o_cen, o_stk;
  logic [VW-1:0] o_vrt;
  logic [3:0]    o_cr6;
  logic          p_en, p_sat, p_cen, p_stk;
  logic [31:0]   p_vrt;
  logic [3:0]    p_cr6;
  logic          q_en, q_sat, q_cen, q_stk;
  logic [VW-1:0] q_vrt;
  logic [3:0]    q_cr6;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int            due;
    logic [VW-1:0] v;
    logic          s;
    logic          rec;
    logic [3:0]    c;
  } exp_t;
  exp_t sb[$];

  vsfx_pipe #(.VW(VW), .LAT(LAT_M)) dut (
    .clk(clk), .rst(rst), .en(en), .vra(vra), .vrb(vrb), .op(op), .flush(flush), .sat_clr(sat_clr),
    .vrt_en(o_en), .vrt(o_vrt), .sat(o_sat), .cr6_en(o_cen), .cr6(o_cr6), .sat_sticky(o_stk));

  vsfx_pipe #(.VW(32), .LAT(1)) dut_l1 (
    .clk(clk), .rst(rst), .en(en), .vra(vra[31:0]), .vrb(vrb[31:0]), .op(op), .flush(flush),
    .sat_clr(sat_clr), .vrt_en(p_en), .vrt(p_vrt), .sat(p_sat), .cr6_en(p_cen), .cr6(p_cr6),
    .sat_sticky(p_stk));

  vsfx_pipe #(.VW(VW), .LAT(4)) dut_l4 (
    .clk(clk), .rst(rst), .en(en), .vra(vra), .vrb(vrb), .op(op), .flush(flush), .sat_clr(sat_clr),
    .vrt_en(q_en), .vrt(q_vrt), .sat(q_sat), .cr6_en(q_cen), .cr6(q_cr6), .sat_sticky(q_stk));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; flush = 1'b0; sat_clr = 1'b0; vra = '0; vrb = '0; op = '0;
  endtask

  function automatic logic [7:0] mkop(input logic [2:0] f, input logic [1:0] z,
                                      input logic s, input logic m, input logic r);
    return {f, z, s, m, r};
  endfunction

  // Reference: lanes are treated as plain integers, and the result is wrapped or clamped afterwards.
  function automatic void ref_op(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [7:0] o,
                                 output logic [VW-1:0] r, output logic s, output logic [3:0] c,
                                 output logic rec);
    int w;
    longint m, hi, lo, va, vb, x;
    logic t, all_t, any_t;
    w  = (o[4:3] == 2'b00) ? 8 : (o[4:3] == 2'b01) ? 16 : 32;
    m  = (longint'(1) << w) - 1;
    hi = o[2] ? (m >> 1) : m;
    lo = o[2] ? -hi - 1 : 0;
    r = '0; s = 1'b0; all_t = 1'b1; any_t = 1'b0;
    for (int i = 0; i < VW / w; i++) begin
      va = longint'(32'(a >> (i * w))) & m;
      vb = longint'(32'(b >> (i * w))) & m;
      if (o[2] && va > hi) va = va - m - 1;
      if (o[2] && vb > hi) vb = vb - m - 1;
      t = 1'b0;
      x = 0;
      case (o[7:5])
        3'd0, 3'd1: begin
          x = (o[7:5] == 3'd0) ? va + vb : va - vb;
          if (o[1] && x > hi) begin x = hi; s = 1'b1; end
          else if (o[1] && x < lo) begin x = lo; s = 1'b1; end
        end
        3'd2: x = (va > vb) ? va : vb;
        3'd3: x = (va < vb) ? va : vb;
        3'd4: x = (va + vb + 1) >>> 1;
        3'd5: begin t = (va == vb); x = t ? m : 0; end
        3'd6: begin t = (va > vb); x = t ? m : 0; end
        default: x = 0;
      endcase
      all_t = all_t & t;
      any_t = any_t | t;
      r = r | (VW'(x & m) << (i * w));
    end
    c   = {all_t, 1'b0, ~any_t, 1'b0};
    rec = o[0] && (o[7:5] == 3'd5 || o[7:5] == 3'd6);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) tick();
    n_chk++;
    if ({o_en, o_sat, o_cen, o_cr6, o_stk} !== 8'h00) begin
      n_err++; $display("FAIL reset_flags: got %b required 00000000", {o_en, o_sat, o_cen, o_cr6, o_stk});
    end
    n_chk++;
    if (o_vrt !== '0) begin n_err++; $display("FAIL reset_vrt: got %h required 0", o_vrt); end
    n_chk++;
    if ({p_en, q_en, p_stk, q_stk, p_vrt} !== 36'd0) begin
      n_err++; $display("FAIL reset_other: got %b %b %b %b %h", p_en, q_en, p_stk, q_stk, p_vrt);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sat_add();
    idle_inputs();
    vra[7:0] = 8'hF0; vrb[7:0] = 8'h20; op = mkop(3'd0, 2'd0, 1'b0, 1'b1, 1'b0); en = 1'b1;
    tick();
    en = 1'b0;
    n_chk++;
    if (o_en !== 1'b0) begin n_err++; $display("FAIL satadd_early: vrt_en got %b required 0", o_en); end
    tick();
    n_chk++;
    if ({o_en, o_sat, o_cen} !== 3'b110 || o_vrt !== VW'(8'hFF)) begin
      n_err++; $display("FAIL satadd_result: en/sat/cr6en %b vrt %h required 110 / ff", {o_en, o_sat, o_cen}, o_vrt);
    end
    tick();
    n_chk++;
    if ({o_en, o_stk} !== 2'b01 || o_vrt !== VW'(8'hFF)) begin
      n_err++; $display("FAIL satadd_sticky: en/sticky %b vrt %h required 01 / ff held", {o_en, o_stk}, o_vrt);
    end
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    n_chk++;
    if (o_stk !== 1'b0) begin n_err++; $display("FAIL satadd_clr: sticky got %b required 0", o_stk); end
  endtask

  task automatic test_half_sub();
    idle_inputs();
    vra[15:0] = 16'h8000; vrb[15:0] = 16'h0001; op = mkop(3'd1, 2'd1, 1'b1, 1'b1, 1'b0); en = 1'b1;
    tick();
    op = mkop(3'd1, 2'd1, 1'b1, 1'b0, 1'b0);
    tick();
    en = 1'b0;
    n_chk++;
    if ({o_en, o_sat} !== 2'b11 || o_vrt !== VW'(16'h8000)) begin
      n_err++; $display("FAIL halfsub_sat: en/sat %b vrt %h required 11 / 8000", {o_en, o_sat}, o_vrt);
    end
    tick();
    n_chk++;
    if ({o_en, o_sat} !== 2'b10 || o_vrt !== VW'(16'h7FFF)) begin
      n_err++; $display("FAIL halfsub_mod: en/sat %b vrt %h required 10 / 7fff", {o_en, o_sat}, o_vrt);
    end
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
  endtask

  task automatic test_cmpgt();
    idle_inputs();
    vra = {4{32'h0000_0001}}; vrb = {4{32'hFFFF_FFFF}}; op = mkop(3'd6, 2'd2, 1'b1, 1'b0, 1'b1); en = 1'b1;
    tick();
    vra = {4{32'hFFFF_FFFF}}; vrb = {4{32'h0000_0001}};
    tick();
    en = 1'b0;
    n_chk++;
    if ({o_en, o_cen, o_cr6} !== 6'b11_1000 || o_vrt !== {VW{1'b1}}) begin
      n_err++; $display("FAIL cmpgt_true: en/cr6en/cr6 %b vrt %h required 111000 / all ones", {o_en, o_cen, o_cr6}, o_vrt);
    end
    tick();
    n_chk++;
    if ({o_en, o_cen, o_cr6} !== 6'b11_0010 || o_vrt !== '0) begin
      n_err++; $display("FAIL cmpgt_false: en/cr6en/cr6 %b vrt %h required 110010 / 0", {o_en, o_cen, o_cr6}, o_vrt);
    end
    tick();
    n_chk++;
    if ({o_en, o_cen, o_cr6} !== 6'b00_0010) begin
      n_err++; $display("FAIL cmpgt_hold: en/cr6en/cr6 %b required 000010", {o_en, o_cen, o_cr6});
    end
  endtask

  task automatic test_flush();
    logic [2:0] want [4];
    want[0] = 3'b010; want[1] = 3'b100; want[2] = 3'b000; want[3] = 3'b001;
    idle_inputs();
    repeat (6) tick();
    for (int i = 0; i < 4; i++) begin
      vra = {$urandom, $urandom, $urandom, $urandom};
      vrb = {$urandom, $urandom, $urandom, $urandom};
      op = mkop(3'd0, 2'd0, 1'b0, 1'b0, 1'b0); en = 1'b1;
      tick();
    end
    vra = '0; vrb = '0; vra[7:0] = 8'h11; vrb[7:0] = 8'h22; flush = 1'b1;
    tick();
    en = 1'b0; flush = 1'b0;
    for (int t = 0; t < 4; t++) begin
      n_chk++;
      if ({o_en, p_en, q_en} !== want[t]) begin
        n_err++; $display("FAIL flush_valid[%0d]: vrt_en lat2/lat1/lat4 %b required %b", t, {o_en, p_en, q_en}, want[t]);
      end
      if (t == 0) begin
        n_chk++;
        if (p_vrt !== 32'h33) begin n_err++; $display("FAIL flush_lat1_data: got %h required 33", p_vrt); end
      end
      if (t == 1) begin
        n_chk++;
        if (o_vrt !== VW'(8'h33)) begin n_err++; $display("FAIL flush_lat2_data: got %h required 33", o_vrt); end
      end
      if (t == 3) begin
        n_chk++;
        if (q_vrt !== VW'(8'h33)) begin n_err++; $display("FAIL flush_lat4_data: got %h required 33", q_vrt); end
      end
      tick();
    end
  endtask

  task automatic test_avg_latency();
    int t_m, t_1, t_4;
    logic [7:0] v_m, v_1, v_4;
    t_m = 0; t_1 = 0; t_4 = 0; v_m = '0; v_1 = '0; v_4 = '0;
    idle_inputs();
    repeat (6) tick();
    vra[7:0] = 8'hFF; op = mkop(3'd4, 2'd0, 1'b0, 1'b0, 1'b0); en = 1'b1;
    tick();
    en = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      if (o_en && t_m == 0) begin t_m = t; v_m = o_vrt[7:0]; end
      if (p_en && t_1 == 0) begin t_1 = t; v_1 = p_vrt[7:0]; end
      if (q_en && t_4 == 0) begin t_4 = t; v_4 = q_vrt[7:0]; end
      tick();
    end
    n_chk++;
    if (t_m != 2 || v_m !== 8'h80) begin n_err++; $display("FAIL avg_lat2: cycles %0d value %h required 2 / 80", t_m, v_m); end
    n_chk++;
    if (t_1 != 1 || v_1 !== 8'h80) begin n_err++; $display("FAIL avg_lat1: cycles %0d value %h required 1 / 80", t_1, v_1); end
    n_chk++;
    if (t_4 != 4 || v_4 !== 8'h80) begin n_err++; $display("FAIL avg_lat4: cycles %0d value %h required 4 / 80", t_4, v_4); end
  endtask

  task automatic test_reset_midop();
    idle_inputs();
    repeat (6) tick();
    vra[7:0] = 8'hF0; vrb[7:0] = 8'h20; op = mkop(3'd0, 2'd0, 1'b0, 1'b1, 1'b0); en = 1'b1;
    tick();
    tick();
    en = 1'b0;
    n_chk++;
    if ({o_en, o_sat} !== 2'b11) begin n_err++; $display("FAIL rstmid_pre: en/sat %b required 11", {o_en, o_sat}); end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({o_en, o_sat, o_cen, o_cr6, o_stk} !== 8'h00 || o_vrt !== '0 || q_en !== 1'b0) begin
      n_err++; $display("FAIL rstmid_async: flags %b vrt %h lat4 en %b required all 0", {o_en, o_sat, o_cen, o_cr6, o_stk}, o_vrt, q_en);
    end
    tick();
    #2 rst = 1'b0;
    for (int t = 0; t < 6; t++) begin
      tick();
      n_chk++;
      if ({o_en, p_en, q_en, o_stk} !== 4'b0000) begin
        n_err++; $display("FAIL rstmid_after[%0d]: en lat2/lat1/lat4 + sticky %b required 0000", t, {o_en, p_en, q_en, o_stk});
      end
    end
  endtask

  task automatic test_random();
    int cyc;
    logic exp_en, exp_cen, stk;
    logic [VW-1:0] h_vrt;
    logic h_sat;
    logic [3:0] h_cr6;
    exp_t e;
    idle_inputs();
    rst = 1'b1;
    #2 rst = 1'b0;
    sb.delete();
    cyc = 0; stk = 1'b0; h_vrt = '0; h_sat = 1'b0; h_cr6 = '0;
    for (int n = 0; n < 400; n++) begin
      exp_en = (sb.size() > 0) && (sb[0].due == cyc);
      exp_cen = 1'b0;
      if (exp_en) begin
        e = sb.pop_front();
        h_vrt = e.v; h_sat = e.s; exp_cen = e.rec;
        if (e.rec) h_cr6 = e.c;
      end
      n_chk++;
      if ({o_en, o_cen} !== {exp_en, exp_cen}) begin
        n_err++; $display("FAIL rand_valid@%0d: en/cr6en %b required %b", cyc, {o_en, o_cen}, {exp_en, exp_cen});
      end
      n_chk++;
      if (o_vrt !== h_vrt) begin n_err++; $display("FAIL rand_vrt@%0d: got %h required %h", cyc, o_vrt, h_vrt); end
      n_chk++;
      if ({o_sat, o_cr6, o_stk} !== {h_sat, h_cr6, stk}) begin
        n_err++; $display("FAIL rand_flags@%0d: sat/cr6/sticky %b required %b", cyc, {o_sat, o_cr6, o_stk}, {h_sat, h_cr6, stk});
      end
      en      = (n < 392) && ($urandom_range(0, 3) != 0);
      flush   = (n < 392) && ($urandom_range(0, 15) == 0);
      sat_clr = ($urandom_range(0, 7) == 0);
      op      = 8'($urandom);
      case ($urandom_range(0, 3))
        0: vra = {16{8'h7F}};
        1: vra = {16{8'h80}};
        default: vra = {$urandom, $urandom, $urandom, $urandom};
      endcase
      case ($urandom_range(0, 3))
        0: vrb = vra;
        1: vrb = ~vra;
        default: vrb = {$urandom, $urandom, $urandom, $urandom};
      endcase
      stk = (stk & ~sat_clr) | (exp_en & h_sat);
      if (flush) sb.delete();
      if (en) begin
        e.due = cyc + LAT_M;
        ref_op(vra, vrb, op, e.v, e.s, e.c, e.rec);
        sb.push_back(e);
      end
      tick();
      cyc++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sat_add();
    test_half_sub();
    test_cmpgt();
    test_flush();
    test_avg_latency();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
